mod_reduce_seq: RTL and testbench

Parametrised sequential modular reducer for the Diffie-Hellman datapath: computes r = exp mod p (and the quotient) by restoring shift-subtract division, one dividend bit per clock. It is the area-reduced successor of the single-cycle remainder stage and feeds the modular-exponentiation loop that produces R1/R2. A start/busy/done handshake replaces the level-sensitive `st` behaviour, and a zero-modulus error is reported.

---
 rtl/dh_pkg.sv | 15 +
 rtl/mod_sub_step.sv | 18 +
 rtl/mod_reduce_seq.sv | 114 +++++++++++
 tb/tb_mod_reduce_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman datapath: controller states,
// default operand widths and the remainder value presented out of reset.
package dh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dh_state_e;

    localparam int DH_DW      = 64;
    localparam int DH_MW      = 32;
    localparam int DH_REM_RST = 1;

endpackage

// File: rtl/mod_sub_step.sv
// One restoring-division step: conditionally subtract the modulus from the
// shifted partial remainder and report whether the subtraction happened.
module mod_sub_step #(
    parameter int MW = 32
) (
    input  logic [MW:0]   rem_in,
    input  logic [MW-1:0] p,
    output logic [MW-1:0] rem_out,
    output logic          q_bit
);

    // rem_in < 2p always holds, so a taken subtraction fits back into MW bits.
    always_comb begin
        q_bit   = (rem_in >= {1'b0, p});
        rem_out = q_bit ? (rem_in[MW-1:0] - p) : rem_in[MW-1:0];
    end

endmodule

// File: rtl/mod_reduce_seq.sv
// Sequential modular reducer: r = exp mod p and q = exp / p by restoring
// shift-subtract division, one dividend bit per clock.
module mod_reduce_seq
    import dh_pkg::*;
#(
    parameter int DW = DH_DW,
    parameter int MW = DH_MW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st,
    input  logic [MW-1:0]   p,
    input  logic [DW-1:0]   exp,
    output logic [MW-1:0]   r,
    output logic [DW-1:0]   q,
    output logic            busy,
    output logic            done,
    output logic            err,
    output dh_state_e       dbg_state
);

    // Handshake: st is accepted on a rising edge only in IDLE or DONE (ignored
    // in RUN, never queued); busy is high for the DW RUN cycles; done is a
    // one-cycle pulse and r/q/err stay valid until the next accepted start.

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    dh_state_e     state;
    logic [DW-1:0] dividend;
    logic [DW-1:0] quo;
    logic [MW-1:0] modulus;
    logic [MW-1:0] rem;
    logic [CW-1:0] cnt;

    logic [MW:0]   rem_shift;
    logic [MW-1:0] rem_next;
    logic          qbit;
    logic [DW-1:0] quo_next;

    assign rem_shift = {rem, dividend[DW-1]};
    assign quo_next  = (quo << 1) | DW'(qbit);
    assign dbg_state = state;

    mod_sub_step #(
        .MW(MW)
    ) u_step (
        .rem_in (rem_shift),
        .p      (modulus),
        .rem_out(rem_next),
        .q_bit  (qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            dividend <= '0;
            quo      <= '0;
            modulus  <= '0;
            rem      <= '0;
            cnt      <= '0;
            r        <= MW'(DH_REM_RST);
            q        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (st) begin
                        dividend <= exp;
                        modulus  <= p;
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= CW'(DW - 1);
                        err      <= 1'b0;
                        // A zero modulus has no quotient; report it without running.
                        if (p == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            r     <= '0;
                            q     <= '1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    dividend <= dividend << 1;
                    rem      <= rem_next;
                    quo      <= quo_next;
                    if (cnt == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        r     <= rem_next;
                        q     <= quo_next;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Bench for mod_reduce_seq: directed vectors on the 64/32 instance and an
// operand sweep on a 16/8 instance, checked by a done-driven scoreboard.
module tb_mod_reduce_seq;
    import dh_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        st64;
    logic [31:0] p64;
    logic [63:0] e64;
    logic [31:0] r64;
    logic [63:0] q64;
    logic        busy64, done64, err64;
    dh_state_e   dbg64;

    logic        st16;
    logic [7:0]  p16;
    logic [15:0] e16;
    logic [7:0]  r16;
    logic [15:0] q16;
    logic        busy16, done16, err16;
    dh_state_e   dbg16;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] r;
        logic [63:0] q;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q64[$];
    exp_t exp_q16[$];

    mod_reduce_seq #(.DW(64), .MW(32)) dut64 (
        .clk(clk), .rst(rst), .st(st64), .p(p64), .exp(e64),
        .r(r64), .q(q64), .busy(busy64), .done(done64), .err(err64),
        .dbg_state(dbg64)
    );

    mod_reduce_seq #(.DW(16), .MW(8)) dut16 (
        .clk(clk), .rst(rst), .st(st16), .p(p16), .exp(e16),
        .r(r16), .q(q16), .busy(busy16), .done(done16), .err(err16),
        .dbg_state(dbg16)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitors
    always @(negedge clk) begin
        exp_t e;
        if (rst && done64) begin
            if (exp_q64.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done64_unexpected: done with empty queue at cycle %0d", cyc);
            end else begin
                e = exp_q64.pop_front();
                check("r64", 64'(r64), e.r);
                check("q64", q64, e.q);
                check("err64", 64'(err64), 64'(e.err));
                check("lat64", 64'(cyc), 64'(e.cyc));
                check("busy64_at_done", 64'(busy64), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && done16) begin
            if (exp_q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done16_unexpected: done with empty queue at cycle %0d", cyc);
            end else begin
                e = exp_q16.pop_front();
                check("r16", 64'(r16), e.r);
                check("q16", 64'(q16), e.q);
                check("err16", 64'(err16), 64'(e.err));
                check("lat16", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // driver tasks (called away from the rising edge)
    task automatic start64(input logic [63:0] e, input logic [31:0] pp,
                           input logic [63:0] rr, input logic [63:0] qq, input logic ee);
        exp_t x;
        e64  = e;
        p64  = pp;
        st64 = 1'b1;
        x.r   = rr;
        x.q   = qq;
        x.err = ee;
        x.cyc = cyc + 1 + ((pp == 0) ? 0 : 64);
        exp_q64.push_back(x);
        @(posedge clk);
        #1;
        st64 = 1'b0;
        check("busy64_after_start", 64'(busy64), 64'(pp != 0));
    endtask

    task automatic start16(input logic [15:0] e, input logic [7:0] pp);
        exp_t x;
        e16  = e;
        p16  = pp;
        st16 = 1'b1;
        x.r   = 64'(e % pp);
        x.q   = 64'(e / pp);
        x.err = 1'b0;
        x.cyc = cyc + 1 + 16;
        exp_q16.push_back(x);
        @(posedge clk);
        #1;
        st16 = 1'b0;
    endtask

    task automatic wait_done64();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done64 && n < 200);
        if (!done64) begin
            n_checks++;
            n_fail++;
            $display("FAIL done64_timeout: no done within 200 cycles, cycle %0d", cyc);
        end
    endtask

    task automatic wait_done16();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done16 && n < 100);
        if (!done16) begin
            n_checks++;
            n_fail++;
            $display("FAIL done16_timeout: no done within 100 cycles, cycle %0d", cyc);
        end
    endtask

    initial begin
        logic [15:0] e;
        logic [7:0]  pp;

        st64 = 1'b0; p64 = '0; e64 = '0;
        st16 = 1'b0; p16 = '0; e16 = '0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_r64", 64'(r64), 64'd1);
        check("rst_q64", q64, 64'd0);
        check("rst_busy64", 64'(busy64), 64'd0);
        check("rst_done64", 64'(done64), 64'd0);
        check("rst_err64", 64'(err64), 64'd0);
        check("rst_state64", 64'(dbg64), 64'(ST_IDLE));
        check("rst_r16", 64'(r16), 64'd1);
        rst = 1'b1;
        @(negedge clk);

        start64(64'd100, 32'd7, 64'd2, 64'd14, 1'b0);
        wait_done64();
        @(negedge clk);
        check("hold_done64", 64'(done64), 64'd0);
        check("hold_r64", 64'(r64), 64'd2);
        check("hold_q64", q64, 64'd14);
        check("idle_state64", 64'(dbg64), 64'(ST_IDLE));

        start64(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'h0000_0001_0000_0001, 1'b0);
        wait_done64();
        @(negedge clk);

        start64(64'd5, 32'd9, 64'd5, 64'd0, 1'b0);
        wait_done64();
        @(negedge clk);

        start64(64'd123, 32'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_done64();
        repeat (2) @(negedge clk);
        check("hold_err64", 64'(err64), 64'd1);
        check("hold_q64_zero_p", q64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("hold_r64_zero_p", 64'(r64), 64'd0);

        // new operands offered mid-RUN must be dropped
        start64(64'd1000, 32'd13, 64'd12, 64'd76, 1'b0);
        repeat (9) @(negedge clk);
        e64 = 64'd55;
        p64 = 32'd3;
        st64 = 1'b1;
        @(negedge clk);
        st64 = 1'b0;
        wait_done64();
        // restart straight out of DONE
        start64(64'd12345, 32'd100, 64'd45, 64'd123, 1'b0);
        wait_done64();
        @(negedge clk);

        // asynchronous abort mid-RUN
        start64(64'd100, 32'd7, 64'd2, 64'd14, 1'b0);
        repeat (29) @(negedge clk);
        check("run_busy64", 64'(busy64), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_r64", 64'(r64), 64'd1);
        check("abort_q64", q64, 64'd0);
        check("abort_done64", 64'(done64), 64'd0);
        check("abort_busy64", 64'(busy64), 64'd0);
        check("abort_state64", 64'(dbg64), 64'(ST_IDLE));
        exp_q64.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        start64(64'd77, 32'd10, 64'd7, 64'd7, 1'b0);
        wait_done64();
        @(negedge clk);

        // narrow instance sweep, back-to-back from DONE
        for (int i = 0; i < 1000; i++) begin
            e  = 16'($urandom_range(0, 65535));
            pp = 8'($urandom_range(1, 255));
            start16(e, pp);
            wait_done16();
        end

        repeat (5) @(negedge clk);
        check("q64_drained", 64'(exp_q64.size()), 64'd0);
        check("q16_drained", 64'(exp_q16.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
